// File: rtl/design_pkg.sv
// Shared widths, field type and mode encoding for the SO_ML field selector.
package design_pkg;

    localparam int unsigned FIELD_W    = 2;
    localparam int unsigned NUM_FIELDS = 8;
    localparam int unsigned IN_W       = 16;
    localparam int unsigned SEL_W      = 3;

    typedef logic [FIELD_W-1:0] field_t;

    typedef enum logic {
        MODE_SUMMARY = 1'b0,
        MODE_FIELD   = 1'b1
    } mode_e;

endpackage

// File: rtl/design_field_mux.sv
// Combinational 8:1 selector of 2-bit fields from a 16-bit word.
module design_field_mux
    import design_pkg::*;
(
    input  logic [IN_W-1:0]  en,
    input  logic [SEL_W-1:0] index1,
    output field_t           field
);

    // Field k starts at bit 2k, so the bit offset is index1 with a zero appended.
    always_comb begin
        field = en[{index1, 1'b0} +: FIELD_W];
    end

endmodule

// File: rtl/blk_0d2f74.sv
// Registered field selector: one selected field or a per-byte activity summary each cycle.
module blk_0d2f74
    import design_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  en,
    input  logic             index,
    input  logic [SEL_W-1:0] index1,
    output logic [1:0]       OUT
);

    field_t field_sel;
    field_t summary;
    field_t out_d;
    field_t out_q;
    mode_e  mode;

    design_field_mux u_field_mux (
        .en     (en),
        .index1 (index1),
        .field  (field_sel)
    );

    assign mode = mode_e'(index);

    always_comb begin
        summary = {|en[15:8], |en[7:0]};
    end

    always_comb begin
        out_d = summary;
        if (mode == MODE_FIELD) begin
            out_d = field_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign OUT = out_q;

endmodule

// File: tb/tb_blk_0d2f74.sv
// Self-checking bench for blk_0d2f74: vector table, randomized model check, reset/mode sequences.
module tb_blk_0d2f74;

    logic        clk;
    logic        rst;
    logic [15:0] en;
    logic        index;
    logic [2:0]  index1;
    logic [1:0]  OUT;

    int vectors;
    int miscompares;

    typedef struct {
        logic [15:0] en;
        logic        index;
        logic [2:0]  index1;
        logic [1:0]  exp;
    } vec_t;

    blk_0d2f74 dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .index  (index),
        .index1 (index1),
        .OUT    (OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: field k is (word / 4^k) mod 4; summary flags a nonzero byte.
    function automatic logic [1:0] model(input logic [15:0] w, input logic m, input logic [2:0] k);
        int unsigned v;
        int unsigned kk;
        v  = w;
        kk = k;
        if (m) begin
            return 2'((v >> (2 * kk)) % 4);
        end
        return {((v / 256) != 0), ((v % 256) != 0)};
    endfunction

    task automatic chk(input string name, input logic [1:0] exp);
        vectors++;
        if (OUT !== exp) begin
            miscompares++;
            $display("FAIL %s: OUT=%b expected %b", name, OUT, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Zero data sweep, field select sweep on 0xE4E4, summary cases
        for (int i = 0; i < 4; i++) tbl.push_back('{16'h0000, 1'b1, 3'(i), 2'b00});
        for (int i = 0; i < 8; i++) tbl.push_back('{16'hE4E4, 1'b1, 3'(i), 2'(i % 4)});
        tbl.push_back('{16'h0100, 1'b0, 3'd0, 2'b10});
        tbl.push_back('{16'h0001, 1'b0, 3'd5, 2'b01});
        tbl.push_back('{16'h8001, 1'b0, 3'd2, 2'b11});
        tbl.push_back('{16'h0000, 1'b0, 3'd7, 2'b00});
        tbl.push_back('{16'hC000, 1'b1, 3'd7, 2'b11});
        tbl.push_back('{16'h0002, 1'b1, 3'd0, 2'b10});

        // Asynchronous reset with no clock edge
        rst    = 1'b0;
        en     = 16'hFFFF;
        index  = 1'b1;
        index1 = 3'd0;
        #2 rst = 1'b1;
        #1 chk("reset_async", 2'b00);
        step();
        chk("reset_hold_edge1", 2'b00);
        step();
        chk("reset_hold_edge2", 2'b00);
        rst = 1'b0;
        #1 chk("reset_release_pre_edge", 2'b00);
        step();
        chk("reset_release_first_edge", 2'b11);

        // Table-driven vectors
        foreach (tbl[i]) begin
            en     = tbl[i].en;
            index  = tbl[i].index;
            index1 = tbl[i].index1;
            step();
            chk($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Mode switch: index1 ignored in summary mode
        en     = 16'h0003;
        index1 = 3'd0;
        index  = 1'b1;
        step();
        chk("mode_field", 2'b11);
        index = 1'b0;
        step();
        chk("mode_summary", 2'b01);
        index1 = 3'd7;
        step();
        chk("mode_summary_idx_ignored", 2'b01);

        // Mid-run reset during field sweep
        en    = 16'hE4E4;
        index = 1'b1;
        for (int k = 0; k < 8; k++) begin
            index1 = 3'(k);
            step();
            chk($sformatf("midrun_sweep[%0d]", k), 2'(k % 4));
            if (k == 3) begin
                #2 rst = 1'b1;
                #1 chk("midrun_async_clear", 2'b00);
                #1 rst = 1'b0;
                #1 chk("midrun_post_release", 2'b00);
            end
        end

        // Randomized against the reference model
        for (int i = 0; i < 200; i++) begin
            logic [1:0] exp;
            en     = 16'($urandom);
            if ((i % 7) == 0) en = 16'h0000;
            index  = 1'($urandom);
            index1 = 3'($urandom_range(0, 7));
            exp    = model(en, index, index1);
            step();
            chk($sformatf("random[%0d] en=%h m=%0d k=%0d", i, en, index, index1), exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
